// File: rtl/sap1_fetch_unit.sv
// SAP-1 fetch datapath: program counter, memory address register and
// instruction register, plus the W bus drive logic for PC and IR operand.
// Optional feature macro: FETCH_HLT_FREEZE_EN -- when defined, HLT_bar=0
// freezes PC, MAR and IR; when undefined HLT_bar is ignored.
module sap1_fetch_unit #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     C_P,
    input  logic                     E_P,
    input  logic                     L_M_bar,
    input  logic                     L_I_bar,
    input  logic                     E_I_bar,
    input  logic                     HLT_bar,
    input  logic [DATA_W-1:0]        W_bus_in,
    output logic [DATA_W-1:0]        W_bus_out,
    output logic                     W_bus_drive,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-ADDR_W-1:0] instruction,
    output logic [ADDR_W-1:0]        pc_value,
    output logic                     bus_conflict
);

    localparam int OPC_W = DATA_W - ADDR_W;

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] mar_r;
    logic [DATA_W-1:0] ir_r;
    logic              conflict_r;
    logic              hold_s;
    logic [DATA_W-1:0] bus_out_s;
    logic              bus_drive_s;

`ifdef FETCH_HLT_FREEZE_EN
    assign hold_s = ~HLT_bar;
`else
    // Halt is handled by clock gating elsewhere in this build.
    logic unused_hlt_s;
    assign unused_hlt_s = HLT_bar;
    assign hold_s       = 1'b0;
`endif

    // Program counter: increments modulo 2**ADDR_W on C_P, no carry out.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            pc_r <= {ADDR_W{1'b0}};
        end else if (!hold_s && C_P) begin
            pc_r <= pc_r + ADDR_W'(1);
        end else begin
            pc_r <= pc_r;
        end
    end

    // MAR: captures the low address bits of the W bus; upper bits dropped.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            mar_r <= {ADDR_W{1'b0}};
        end else if (!hold_s && !L_M_bar) begin
            mar_r <= W_bus_in[ADDR_W-1:0];
        end else begin
            mar_r <= mar_r;
        end
    end

    // Instruction register: captures the full W bus word.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            ir_r <= {DATA_W{1'b0}};
        end else if (!hold_s && !L_I_bar) begin
            ir_r <= W_bus_in;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Sticky flag: PC and IR operand both asked for the bus; only CLR clears it.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            conflict_r <= 1'b0;
        end else if (E_P && !E_I_bar) begin
            conflict_r <= 1'b1;
        end else begin
            conflict_r <= conflict_r;
        end
    end

    // Bus source select: PC has priority over the IR operand; zero when idle.
    always_comb begin
        bus_out_s   = {DATA_W{1'b0}};
        bus_drive_s = 1'b0;
        if (E_P) begin
            bus_out_s   = {{OPC_W{1'b0}}, pc_r};
            bus_drive_s = 1'b1;
        end else if (!E_I_bar) begin
            bus_out_s   = {{OPC_W{1'b0}}, ir_r[ADDR_W-1:0]};
            bus_drive_s = 1'b1;
        end else begin
            bus_out_s   = {DATA_W{1'b0}};
            bus_drive_s = 1'b0;
        end
    end

    assign W_bus_out    = bus_out_s;
    assign W_bus_drive  = bus_drive_s;
    assign mem_addr     = mar_r;
    assign instruction  = ir_r[DATA_W-1:ADDR_W];
    assign pc_value     = pc_r;
    assign bus_conflict = conflict_r;

endmodule

// File: tb/tb_sap1_fetch_unit.sv
// Directed self-checking bench for sap1_fetch_unit with a small RAM and
// a W bus model (DUT drive wins, otherwise RAM or an external source).
module tb_sap1_fetch_unit;

    logic       CLK;
    logic       CLR;
    logic       C_P;
    logic       E_P;
    logic       L_M_bar;
    logic       L_I_bar;
    logic       E_I_bar;
    logic       HLT_bar;
    logic [7:0] W_bus_in;
    logic [7:0] W_bus_out;
    logic       W_bus_drive;
    logic [3:0] mem_addr;
    logic [3:0] instruction;
    logic [3:0] pc_value;
    logic       bus_conflict;

    logic [7:0] ram [16];
    logic       ram_en;
    logic [7:0] ext_val;

    int total;
    int bad;

    sap1_fetch_unit #(.ADDR_W(4), .DATA_W(8)) dut (
        .CLK          (CLK),
        .CLR          (CLR),
        .C_P          (C_P),
        .E_P          (E_P),
        .L_M_bar      (L_M_bar),
        .L_I_bar      (L_I_bar),
        .E_I_bar      (E_I_bar),
        .HLT_bar      (HLT_bar),
        .W_bus_in     (W_bus_in),
        .W_bus_out    (W_bus_out),
        .W_bus_drive  (W_bus_drive),
        .mem_addr     (mem_addr),
        .instruction  (instruction),
        .pc_value     (pc_value),
        .bus_conflict (bus_conflict)
    );

    assign W_bus_in = W_bus_drive ? W_bus_out : (ram_en ? ram[mem_addr] : ext_val);

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        C_P = 1'b0; E_P = 1'b0; L_M_bar = 1'b1; L_I_bar = 1'b1;
        E_I_bar = 1'b1; HLT_bar = 1'b1; ram_en = 1'b0;
    endtask

    task automatic step_pc(input int n);
        C_P = 1'b1;
        for (int i = 0; i < n; i++) tick();
        C_P = 1'b0;
    endtask

    task automatic clr_pulse();
        #1 CLR = 1'b1;
        #1 CLR = 1'b0;
    endtask

    logic [3:0] exp_op [3];
    logic [3:0] exp_opnd [3];

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        ram[0] = 8'h09; ram[1] = 8'h1A; ram[2] = 8'hE0;
        exp_op   = '{4'h0, 4'h1, 4'hE};
        exp_opnd = '{4'h9, 4'hA, 4'h0};
        ext_val = 8'h00;
        idle();
        CLR = 1'b1;
        #2;
        check_val("rst_pc", 32'(pc_value), 32'h0);
        check_val("rst_mar", 32'(mem_addr), 32'h0);
        check_val("rst_instr", 32'(instruction), 32'h0);
        check_val("rst_conflict", 32'(bus_conflict), 32'h0);
        check_val("rst_drive", 32'(W_bus_drive), 32'h0);
        CLR = 1'b0;

        // Three T1..T3 fetches from RAM
        for (int k = 0; k < 3; k++) begin
            E_P = 1'b1; L_M_bar = 1'b0;
            #1;
            check_val("t1_bus", 32'(W_bus_out), 32'(k));
            tick();
            E_P = 1'b0; L_M_bar = 1'b1;
            check_val("t1_mar", 32'(mem_addr), 32'(k));
            C_P = 1'b1;
            tick();
            C_P = 1'b0;
            check_val("t2_pc", 32'(pc_value), 32'(k + 1));
            ram_en = 1'b1; L_I_bar = 1'b0;
            tick();
            ram_en = 1'b0; L_I_bar = 1'b1;
            check_val("t3_opcode", 32'(instruction), 32'(exp_op[k]));
            E_I_bar = 1'b0;
            #1;
            check_val("t3_operand", 32'(W_bus_out), 32'(exp_opnd[k]));
            E_I_bar = 1'b1;
        end
        check_val("fetch_pc_end", 32'(pc_value), 32'h3);

        // Asynchronous CLR mid-run with PC=7, IR=E5
        step_pc(4);
        ext_val = 8'hE5; L_I_bar = 1'b0;
        tick();
        L_I_bar = 1'b1;
        ext_val = 8'h3B; L_M_bar = 1'b0;
        tick();
        L_M_bar = 1'b1;
        check_val("pre_clr_pc", 32'(pc_value), 32'h7);
        check_val("pre_clr_instr", 32'(instruction), 32'hE);
        check_val("mar_low_bits", 32'(mem_addr), 32'hB);
        #2 CLR = 1'b1; E_P = 1'b1;
        #1;
        check_val("clr_pc", 32'(pc_value), 32'h0);
        check_val("clr_mar", 32'(mem_addr), 32'h0);
        check_val("clr_instr", 32'(instruction), 32'h0);
        check_val("clr_drive_ep", 32'(W_bus_drive), 32'h1);
        check_val("clr_bus_ep", 32'(W_bus_out), 32'h0);
        E_P = 1'b0; E_I_bar = 1'b0;
        #1;
        check_val("clr_ir_operand", 32'(W_bus_out), 32'h0);
        E_I_bar = 1'b1;
        tick();
        CLR = 1'b0;

        // PC wrap 15 -> 0, other state untouched
        ext_val = 8'h5A; L_I_bar = 1'b0;
        tick();
        L_I_bar = 1'b1;
        ext_val = 8'h06; L_M_bar = 1'b0;
        tick();
        L_M_bar = 1'b1;
        step_pc(15);
        check_val("pc_15", 32'(pc_value), 32'hF);
        step_pc(1);
        check_val("pc_wrap", 32'(pc_value), 32'h0);
        check_val("wrap_mar_hold", 32'(mem_addr), 32'h6);
        check_val("wrap_instr_hold", 32'(instruction), 32'h5);

        // IR operand onto bus into MAR
        ext_val = 8'h2C; L_I_bar = 1'b0;
        tick();
        L_I_bar = 1'b1;
        E_I_bar = 1'b0; L_M_bar = 1'b0;
        #1;
        check_val("ir_bus", 32'(W_bus_out), 32'h0C);
        check_val("ir_drive", 32'(W_bus_drive), 32'h1);
        tick();
        idle();
        check_val("ir_to_mar", 32'(mem_addr), 32'hC);
        check_val("no_conflict", 32'(bus_conflict), 32'h0);

        // Bus conflict, sticky until CLR
        clr_pulse();
        step_pc(5);
        E_P = 1'b1; E_I_bar = 1'b0;
        #1;
        check_val("conf_bus", 32'(W_bus_out), 32'h05);
        check_val("conf_drive", 32'(W_bus_drive), 32'h1);
        check_val("conf_pre_edge", 32'(bus_conflict), 32'h0);
        tick();
        idle();
        check_val("conf_set", 32'(bus_conflict), 32'h1);
        tick(); tick(); tick();
        check_val("conf_sticky", 32'(bus_conflict), 32'h1);
        check_val("conf_pc_hold", 32'(pc_value), 32'h5);
        clr_pulse();
        check_val("conf_cleared", 32'(bus_conflict), 32'h0);

        // Halt input
        HLT_bar = 1'b0; C_P = 1'b1; L_I_bar = 1'b0; L_M_bar = 1'b0; ext_val = 8'h77;
        tick();
        idle();
`ifdef FETCH_HLT_FREEZE_EN
        check_val("hlt_pc", 32'(pc_value), 32'h0);
        check_val("hlt_instr", 32'(instruction), 32'h0);
        check_val("hlt_mar", 32'(mem_addr), 32'h0);
`else
        check_val("hlt_pc", 32'(pc_value), 32'h1);
        check_val("hlt_instr", 32'(instruction), 32'h7);
        check_val("hlt_mar", 32'(mem_addr), 32'h7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
